// File: rtl/writeback_unit.sv
// writeback_unit: in-order result queue feeding the regfile write port, plus a per-register busy scoreboard.
// Optional: define ZERO_REG_EN to make register 0 a hardwired zero (writes suppressed, never busy).
module writeback_unit #(
  parameter int WIDTH        = 24,
  parameter int REGNUM       = 8,
  parameter int ADDRESSWIDTH = 3,
  parameter int DEPTH        = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       aluValid,
  input  logic [ADDRESSWIDTH-1:0]    aluAddress,
  input  logic [WIDTH-1:0]           aluData,
  output logic                       aluReady,
  input  logic                       memValid,
  input  logic [ADDRESSWIDTH-1:0]    memAddress,
  input  logic [WIDTH-1:0]           memData,
  output logic                       memReady,
  input  logic                       issueValid,
  input  logic [ADDRESSWIDTH-1:0]    issueAddress,
  output logic                       writeEnable,
  output logic [ADDRESSWIDTH-1:0]    writeAddress,
  output logic [WIDTH-1:0]           dataToSave,
  output logic [REGNUM-1:0]          busyMask,
  output logic [$clog2(DEPTH+1)-1:0] queueCount
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  logic [ADDRESSWIDTH-1:0] qa_q [DEPTH];
  logic [WIDTH-1:0]        qd_q [DEPTH];
  logic [PW-1:0]           head_q, head_d, tail_q, tail_d, alu_ptr;
  logic [CW-1:0]           count_q, count_d;
  logic [REGNUM-1:0]       busy_q, busy_d;
  logic                    we_q, we_d;
  logic [ADDRESSWIDTH-1:0] wa_q, head_addr;
  logic [WIDTH-1:0]        wd_q;
  logic                    mem_acc, alu_acc, deq;

  // Readiness looks only at the registered count; a same-cycle pop grants no extra credit.
  assign memReady  = {1'b0, count_q} < DEPTH_W;
  assign aluReady  = ({1'b0, count_q} + {{CW{1'b0}}, memValid}) < DEPTH_W;
  assign mem_acc   = memValid & memReady;
  assign alu_acc   = aluValid & aluReady;
  assign deq       = count_q != '0;
  assign head_addr = qa_q[head_q];
  assign alu_ptr   = mem_acc ? nxt(tail_q) : tail_q;

  always_comb begin
    head_d  = deq ? nxt(head_q) : head_q;
    tail_d  = alu_acc ? nxt(alu_ptr) : (mem_acc ? nxt(tail_q) : tail_q);
    count_d = count_q + CW'(mem_acc) + CW'(alu_acc) - CW'(deq);
`ifdef ZERO_REG_EN
    we_d    = deq && (head_addr != '0);
`else
    we_d    = deq;
`endif
    busy_d  = busy_q;
    if (deq) busy_d[head_addr] = 1'b0;
    if (issueValid) busy_d[issueAddress] = 1'b1;
`ifdef ZERO_REG_EN
    busy_d[0] = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (mem_acc) begin
      qa_q[tail_q] <= memAddress;
      qd_q[tail_q] <= memData;
    end
    if (alu_acc) begin
      qa_q[alu_ptr] <= aluAddress;
      qd_q[alu_ptr] <= aluData;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      if (we_d) begin
        wa_q <= head_addr;
        wd_q <= qd_q[head_q];
      end
    end
  end

  assign writeEnable  = we_q;
  assign writeAddress = wa_q;
  assign dataToSave   = wd_q;
  assign busyMask     = busy_q;
  assign queueCount   = count_q;
endmodule
